// File: rtl/multi38_2_seq_if.sv
// Valid/ready bus between the part-1 CSA tree, the carry-propagate stage and the
// downstream consumer: carry-save pair in, resolved product out.
interface multi38_2_seq_if #(
    parameter int W = 38
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] cs_c;
    logic [W-1:0] cs_s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] prod;

    // Upstream/downstream environment drives pairs and accepts products
    modport master (
        output in_valid, cs_c, cs_s, out_ready,
        input  in_ready, out_valid, prod
    );

    // The carry-propagate stage itself
    modport slave (
        input  in_valid, cs_c, cs_s, out_ready,
        output in_ready, out_valid, prod
    );
endinterface

// File: rtl/multi38_2_seq.sv
// Second half of the 31x8 signed multiplier: resolves the carry-save pair with an
// SLICE-bit-per-cycle carry-propagate adder. Optional accumulator: MULTI38_ACC_EN.
module multi38_2_seq #(
    parameter int W     = 38,
    parameter int SLICE = 8
`ifdef MULTI38_ACC_EN
    ,
    parameter int ACC_W = 46
`endif
) (
    input  logic           clk,
    input  logic           rst,
    multi38_2_seq_if.slave bus
`ifdef MULTI38_ACC_EN
    ,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc
`endif
);

    localparam int NSL   = (W + SLICE - 1) / SLICE;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_prod;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE:0]   w_sum;
    logic [W-1:0]     w_ins;
    logic [W-1:0]     w_mask;

    // DONE frees the input side in the same cycle the product is taken
    assign w_out_valid = (r_state == S_DONE);
    assign w_in_ready  = (r_state == S_IDLE) || (w_out_valid && bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.prod      = r_prod;

    // Slice k of both operands plus the running carry; the top slice's upper
    // bits are zero after the shift and its result bits beyond W fall off.
    assign w_a_sl = SLICE'(r_a >> (r_idx * SLICE));
    assign w_b_sl = SLICE'(r_b >> (r_idx * SLICE));
    assign w_sum  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_carry};
    assign w_ins  = W'(w_sum[SLICE-1:0]) << (r_idx * SLICE);
    assign w_mask = W'({SLICE{1'b1}}) << (r_idx * SLICE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_prod  <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        // cs_c[W-1] is shifted out: part 1 already folded the sign
                        r_a     <= {bus.cs_c[W-2:0], 1'b0};
                        r_b     <= bus.cs_s;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                        r_state <= S_ADD;
                    end else if (w_out_valid && bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ADD: begin
                    r_prod  <= (r_prod & ~w_mask) | w_ins;
                    r_carry <= w_sum[SLICE];
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MULTI38_ACC_EN
    logic [ACC_W-1:0] w_prod_sx;
    logic [ACC_W-1:0] w_acc_base;

    assign w_prod_sx  = {{(ACC_W - W){r_prod[W-1]}}, r_prod};
    assign w_acc_base = acc_clr ? '0 : acc;

    // Clear takes effect before a coincident product is added in
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (w_out_valid && bus.out_ready) begin
            acc <= w_acc_base + w_prod_sx;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_multi38_2_seq.sv
// Directed self-checking bench for multi38_2_seq; accumulator vectors run only
// when MULTI38_ACC_EN is defined.
module tb_multi38_2_seq;

    localparam int W = 38;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic acc_clr = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    multi38_2_seq_if #(.W(W)) bus ();

`ifdef MULTI38_ACC_EN
    logic [45:0] acc;
    multi38_2_seq dut (.clk(clk), .rst(rst), .bus(bus), .acc_clr(acc_clr), .acc(acc));
`else
    multi38_2_seq dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept a pair, measure latency to out_valid, check product, then hand it off
    task automatic transact(input string tag, input logic [W-1:0] c, input logic [W-1:0] s,
                            input logic [W-1:0] exp, input logic clr);
        int cnt;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.cs_c = c;
        bus.cs_s = s;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_latency"}, 64'(cnt), 64'd5);
        check({tag, "_prod"}, 64'(bus.prod), 64'(exp));
        acc_clr = clr;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        check({tag, "_released"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int cnt;
        logic stable;
        logic seen;
        bus.in_valid  = 1'b0;
        bus.cs_c      = '0;
        bus.cs_s      = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_prod", 64'(bus.prod), 64'd0);
`ifdef MULTI38_ACC_EN
        check("rst_acc", 64'(acc), 64'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        transact("t1_small", 38'd0, 38'd15, 38'd15, 1'b0);
        transact("t2_ripple", 38'h7F, 38'h02, 38'h100, 1'b0);
        transact("t3_topdrop", 38'h20_0000_0000, 38'd1, 38'd1, 1'b0);
        transact("t3_minus1", 38'd0, 38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF, 1'b0);
        transact("t_allones", 38'h3F_FFFF_FFFF, 38'd1, 38'h3F_FFFF_FFFF, 1'b0);
        transact("t_longcarry", 38'h15_5555_5555, 38'h0A_AAAA_AAAB, 38'h35_5555_5555, 1'b0);

        // Back-pressure: product must hold and new pairs must be refused
        bus.out_ready = 1'b0;
        bus.cs_c = 38'd0;
        bus.cs_s = 38'h1234;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("bp_latency", 64'(cnt), 64'd5);
        bus.cs_s = 38'h999;
        bus.in_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.prod !== 38'h1234)
                stable = 1'b0;
            @(posedge clk); #1;
        end
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_prod", 64'(bus.prod), 64'h1234);
        bus.cs_c = 38'd1;
        bus.cs_s = 38'd2;
        bus.out_ready = 1'b1;
        #1;
        check("bp_same_cycle_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_took_pair", 64'(bus.out_valid), 64'd0);
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("bp_next_latency", 64'(cnt), 64'd5);
        check("bp_next_prod", 64'(bus.prod), 64'd4);
        @(posedge clk); #1;

        // Reset on the third ADD cycle discards the partial result
        bus.cs_c = 38'h0F_0F0F_0F0F;
        bus.cs_s = 38'h12_3456_789A;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_prod", 64'(bus.prod), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort_never_emitted", 64'(seen), 64'd0);

`ifdef MULTI38_ACC_EN
        transact("acc_p100", 38'd0, 38'd100, 38'd100, 1'b0);
        check("acc_after100", 64'(acc), 64'd100);
        transact("acc_m30", 38'd0, 38'h3F_FFFF_FFE2, 38'h3F_FFFF_FFE2, 1'b0);
        check("acc_after_m30", 64'(acc), 64'd70);
        transact("acc_p7", 38'd0, 38'd7, 38'd7, 1'b0);
        check("acc_sum77", 64'(acc), 64'd77);
        transact("acc_clr_p5", 38'd0, 38'd5, 38'd5, 1'b1);
        check("acc_clr_add5", 64'(acc), 64'd5);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
